seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Programmable multi-pattern serial sequence detector; successor to the fixed 16-bit detector.
//  Shifts a 1-bit serial stream into a SEQ_LEN window; compares it against NUM_PAT runtime-loadable
//  pattern/mask pairs. Gives per-pattern hit pulses, overlap/non-overlap mode and saturating hit counters.
//  Sits after the serial deserialiser front end; consumed by the status/interrupt block.
// PARAMETERS
//  SEQ_LEN   16        window / pattern length in bits (>=2)
//  NUM_PAT   2         number of independent pattern lanes (>=1)
//  CNT_W     8         width of each per-lane saturating hit counter
//  RST_PAT0  16'hABCD  lane 0 pattern after reset (lane 0 mask resets to all-ones)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  reset, asynchronous, active-low
//  in_valid   in   1                  in_bit is a valid stream beat this cycle
//  in_bit     in   1                  serial data bit
//  mode_nonovl in  1                  1 = non-overlapping detection, 0 = overlapping
//  clr        in   1                  sync clear of window, fill, blanking and counters
//  cfg_we     in   1                  write cfg_pat/cfg_mask into lane cfg_idx
//  cfg_idx    in   $clog2(NUM_PAT)    lane select (width 1 when NUM_PAT==1)
//  cfg_pat    in   SEQ_LEN            pattern to load
//  cfg_mask   in   SEQ_LEN            compare mask to load; 1 = bit compared
//  hit        out  NUM_PAT            per-lane one-cycle match pulse
//  hit_any    out  1                  OR of hit
//  hit_cnt    out  NUM_PAT*CNT_W      per-lane counters; lane i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset: window=0, fill=0, all blank=0, hit=0, hit_any=0, hit_cnt=0.
//   Lane 0: pat=RST_PAT0, mask=all-ones. Other lanes: pat=0, mask=0.
//  Shift: on in_valid, win <= {in_bit, win[SEQ_LEN-1:1]}. Newest bit is at the MSB; oldest at bit 0.
//   fill increments, saturating at SEQ_LEN. Without in_valid the window holds.
//  Match_i is evaluated on an in_valid beat against the post-shift window (next-state value). It requires:
//   fill(after beat)==SEQ_LEN, mask_i!=0, ((win_next ^ pat_i) & mask_i)==0, and blank_i==0.
//   No hits occur until SEQ_LEN valid beats have arrived since reset/clr (no false match on zeros).
//  Latency: hit[i] is registered and asserts the cycle after the completing beat. It is a single-cycle pulse.
//   hit_any is registered in the same cycle as hit.
//  mask_i==0: lane i is disabled and never hits.
//  Counter: hit_cnt_i increments on each hit and saturates at 2^CNT_W-1 (no wrap).
//  Overlap mode (mode_nonovl=0): every qualifying beat hits; blank is unused and stays 0.
//  Non-overlap mode: on a hit, blank_i <= SEQ_LEN-1. Each later valid beat decrements blank_i.
//   The next earliest hit is SEQ_LEN beats after the previous one.
//   Clearing mode_nonovl forces all blank counters to 0 on the next cycle.
//  Config: cfg_we updates pat/mask of lane cfg_idx at the clock edge and zeroes that lane's blank.
//   A beat in the same cycle compares against the OLD pat/mask. Window and fill are not disturbed.
//   cfg_idx >= NUM_PAT: write ignored.
//  clr: window, fill, blank, hit_cnt go to 0 next cycle; hit/hit_any are 0 next cycle.
//   clr has priority over a coincident in_valid (beat dropped). pat/mask are kept.
//  Reset mid-stream: all state returns immediately to reset values. Any pending hit pulse is lost.
// STRUCTURE
//  Package seq_det_pkg holds:
//   - typedef lane_cfg_t {logic [SEQ_LEN-1:0] pat, mask;}
//   - blank/fill counter width function clog2(SEQ_LEN+1)
//   - CNT_SAT constant helper
//  Top (seq_det_prog) owns: shift window, fill counter, config write decode, hit_any.
//  Sub-module seq_det_lane, instanced NUM_PAT times via generate, owns:
//   pat/mask regs, masked compare, blank counter, hit register, saturating counter.
// TESTING
//  1. Reset, then serially send 16'hABCD LSB-first (16 beats) -> hit[0]=1 one cycle after beat 16.
//     hit_cnt lane0=1. No hit on any earlier beat, including an all-zero window.
//  2. Overlap: lane1 pat=16'hAAAA, mask=FFFF; send 0,1 alternating x20 beats ->
//     lane1 hits on beats 16,18,20 (3 hits). Non-overlap: same stimulus -> hit on beat 16 only.
//  3. lane1 mask=16'h00FF, pat=16'h00C3: any window with low byte C3 hits; upper bits ignored.
//     mask=0 -> no hit for any stream.
//  4. CNT_W=2, repeat the pattern 5x non-overlap -> hit_cnt saturates at 3 and holds.
//     clr -> 0; the next 15 beats give no hit.
//  5. cfg_we of lane0 on the completing beat -> old pattern still hits.
//     Following beats compare against the new pattern.
//  6. Assert rst low mid-pattern (beat 10) and at the hit cycle -> outputs 0 immediately.
//     The full 16 beats are needed again before any hit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int SEQ_LEN_DEF = 16;

  // Host-side view of one lane's configuration at the default window length.
  typedef struct packed {
    logic [SEQ_LEN_DEF-1:0] pat;
    logic [SEQ_LEN_DEF-1:0] mask;
  } lane_cfg_t;

  // Width of a counter that must hold the values 0..seq_len (fill and blank counters).
  function automatic int ctr_w(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

  // Saturation value of a w-bit hit counter.
  function automatic logic [31:0] cnt_sat(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_lane.sv
// One detector lane: runtime pattern/mask, masked compare against the post-shift
// window, non-overlap blanking, registered hit pulse and saturating hit counter.
module seq_det_lane
  import seq_det_pkg::*;
#(
  parameter int               SEQ_LEN  = 16,
  parameter int               CNT_W    = 8,
  parameter logic [SEQ_LEN-1:0] RST_PAT  = '0,
  parameter logic [SEQ_LEN-1:0] RST_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat,
  input  logic               full,
  input  logic [SEQ_LEN-1:0] win_next,
  input  logic               mode_nonovl,
  input  logic               clr,
  input  logic               cfg_wr,
  input  logic [SEQ_LEN-1:0] cfg_pat,
  input  logic [SEQ_LEN-1:0] cfg_mask,
  output logic               match,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int                 BLANK_W    = ctr_w(SEQ_LEN);
  localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(cnt_sat(CNT_W));

  logic [SEQ_LEN-1:0] pat;
  logic [SEQ_LEN-1:0] mask;
  logic [BLANK_W-1:0] blank;

  // beat is already qualified by clr in the top, so a cleared cycle never matches.
  always_comb begin
    match = beat && full && (mask != '0) &&
            (((win_next ^ pat) & mask) == '0) && (blank == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat     <= RST_PAT;
      mask    <= RST_MASK;
      blank   <= '0;
      hit     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      if (cfg_wr) begin
        pat  <= cfg_pat;
        mask <= cfg_mask;
      end
      if (clr) begin
        hit     <= 1'b0;
        hit_cnt <= '0;
        blank   <= '0;
      end else begin
        hit <= match;
        if (match && (hit_cnt != CNT_MAX)) hit_cnt <= hit_cnt + 1'b1;
        // A reconfigured lane, or overlap mode, always starts unblanked.
        if (cfg_wr || !mode_nonovl) blank <= '0;
        else if (match)             blank <= BLANK_INIT;
        else if (beat && (blank != '0)) blank <= blank - 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable multi-pattern serial sequence detector: shared shift window and
// fill tracking, config write decode, and NUM_PAT independent compare lanes.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN  = 16,
  parameter int                 NUM_PAT  = 2,
  parameter int                 CNT_W    = 8,
  parameter logic [SEQ_LEN-1:0] RST_PAT0 = 16'hABCD,
  localparam int                IDX_W    = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_bit,
  input  logic                     mode_nonovl,
  input  logic                     clr,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [SEQ_LEN-1:0]       cfg_pat,
  input  logic [SEQ_LEN-1:0]       cfg_mask,
  output logic [NUM_PAT-1:0]       hit,
  output logic                     hit_any,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);

  localparam int                FILL_W   = ctr_w(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

  // Only the newest SEQ_LEN-1 bits are stored: compares always use the post-shift
  // window, so the oldest bit would be shifted out before it is ever looked at.
  logic [SEQ_LEN-2:0] win;
  logic [SEQ_LEN-1:0] win_next;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;
  logic               beat;
  logic               full;
  logic [NUM_PAT-1:0] match;

  always_comb begin
    beat      = in_valid & ~clr;
    win_next  = {in_bit, win};
    fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
    full      = (fill_next == FILL_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win     <= '0;
      fill    <= '0;
      hit_any <= 1'b0;
    end else if (clr) begin
      win     <= '0;
      fill    <= '0;
      hit_any <= 1'b0;
    end else begin
      if (beat) begin
        win  <= win_next[SEQ_LEN-1:1];
        fill <= fill_next;
      end
      hit_any <= |match;
    end
  end

  for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
    logic cfg_wr;
    assign cfg_wr = cfg_we && (cfg_idx == IDX_W'(i));

    seq_det_lane #(
      .SEQ_LEN  (SEQ_LEN),
      .CNT_W    (CNT_W),
      .RST_PAT  ((i == 0) ? RST_PAT0 : {SEQ_LEN{1'b0}}),
      .RST_MASK ((i == 0) ? {SEQ_LEN{1'b1}} : {SEQ_LEN{1'b0}})
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .beat        (beat),
      .full        (full),
      .win_next    (win_next),
      .mode_nonovl (mode_nonovl),
      .clr         (clr),
      .cfg_wr      (cfg_wr),
      .cfg_pat     (cfg_pat),
      .cfg_mask    (cfg_mask),
      .match       (match[i]),
      .hit         (hit[i]),
      .hit_cnt     (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios with literal expectations plus a
// randomized stream, all checked every cycle against a bit-history reference model.
module tb_seq_det_prog;

  localparam int SEQ_LEN = 16;
  localparam int NUM_PAT = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_bit = 1'b0;
  logic                     mode_nonovl = 1'b0;
  logic                     clr = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [0:0]               cfg_idx = '0;
  logic [SEQ_LEN-1:0]       cfg_pat = '0;
  logic [SEQ_LEN-1:0]       cfg_mask = '0;
  logic [NUM_PAT-1:0]       hit;
  logic                     hit_any;
  logic [NUM_PAT*CNT_W-1:0] hit_cnt;

  seq_det_prog #(
    .SEQ_LEN  (SEQ_LEN),
    .NUM_PAT  (NUM_PAT),
    .CNT_W    (CNT_W),
    .RST_PAT0 (16'hABCD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .mode_nonovl (mode_nonovl),
    .clr         (clr),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_pat     (cfg_pat),
    .cfg_mask    (cfg_mask),
    .hit         (hit),
    .hit_any     (hit_any),
    .hit_cnt     (hit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int h0 = 0;
  int h1 = 0;

  // Reference model: the stream is kept as a list of received bits (oldest first);
  // non-overlap blanking is expressed as a distance in beats from the last hit.
  bit               q[$];
  logic [SEQ_LEN-1:0] m_pat  [NUM_PAT];
  logic [SEQ_LEN-1:0] m_mask [NUM_PAT];
  int               m_cnt  [NUM_PAT];
  bit               m_hit  [NUM_PAT];
  int               m_last [NUM_PAT];
  bit               m_lastv[NUM_PAT];
  int               m_beats;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NUM_PAT; i++) begin
      m_pat[i]   = (i == 0) ? 16'hABCD : 16'h0000;
      m_mask[i]  = (i == 0) ? 16'hFFFF : 16'h0000;
      m_cnt[i]   = 0;
      m_hit[i]   = 1'b0;
      m_last[i]  = 0;
      m_lastv[i] = 1'b0;
    end
    m_beats = 0;
  endtask

  task automatic model_step();
    bit beat;
    bit ok;
    logic [SEQ_LEN-1:0] w;
    beat = in_valid && !clr;
    if (clr) begin
      q.delete();
      for (int i = 0; i < NUM_PAT; i++) begin
        m_cnt[i]   = 0;
        m_hit[i]   = 1'b0;
        m_lastv[i] = 1'b0;
      end
    end else begin
      if (beat) begin
        q.push_back(in_bit);
        if (q.size() > SEQ_LEN) void'(q.pop_front());
        m_beats++;
      end
      w = '0;
      foreach (q[k]) w[k] = q[k];
      for (int i = 0; i < NUM_PAT; i++) begin
        ok = beat && (q.size() == SEQ_LEN) && (m_mask[i] != '0) &&
             (((w ^ m_pat[i]) & m_mask[i]) == '0) &&
             !(m_lastv[i] && ((m_beats - m_last[i]) < SEQ_LEN));
        m_hit[i] = ok;
        if (ok && (m_cnt[i] < CNT_MAX)) m_cnt[i]++;
        if (ok && mode_nonovl) begin
          m_last[i]  = m_beats;
          m_lastv[i] = 1'b1;
        end
        if (!mode_nonovl) m_lastv[i] = 1'b0;
      end
    end
    if (cfg_we && (int'(cfg_idx) < NUM_PAT)) begin
      m_pat[cfg_idx]   = cfg_pat;
      m_mask[cfg_idx]  = cfg_mask;
      m_lastv[cfg_idx] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  initial begin
    bit any;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        any = 1'b0;
        for (int i = 0; i < NUM_PAT; i++) begin
          chk("lane_hit", int'(hit[i]), int'(m_hit[i]));
          chk("lane_cnt", int'(hit_cnt[i*CNT_W +: CNT_W]), m_cnt[i]);
          any |= m_hit[i];
        end
        chk("hit_any", int'(hit_any), int'(any));
      end
    end
  end

  // One stimulus cycle: first tally hits produced by the previous beat, then drive.
  task automatic cyc(input bit v, input bit b);
    @(negedge clk);
    if (hit[0]) h0++;
    if (hit[1]) h1++;
    in_valid = v;
    in_bit   = b;
    cfg_we   = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic send16(input logic [SEQ_LEN-1:0] p);
    for (int k = 0; k < SEQ_LEN; k++) cyc(1'b1, p[k]);
  endtask

  task automatic do_clr();
    cyc(1'b0, 1'b0);
    clr = 1'b1;
    cyc(1'b0, 1'b0);
  endtask

  task automatic do_cfg(input bit idx, input logic [SEQ_LEN-1:0] p, input logic [SEQ_LEN-1:0] m);
    cyc(1'b0, 1'b0);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_pat  = p;
    cfg_mask = m;
  endtask

  task automatic pulse_rst();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_imm_hit", int'(hit), 0);
    chk("rst_imm_any", int'(hit_any), 0);
    chk("rst_imm_cnt", int'(hit_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [SEQ_LEN-1:0] pa;
    logic [SEQ_LEN-1:0] pn;
    logic [7:0]         c3;
    int                 sh;

    pa = 16'hABCD;
    pn = 16'h1234;
    c3 = 8'hC3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    cmp_en = 1'b1;
    chk("reset_hit", int'(hit), 0);
    chk("reset_cnt", int'(hit_cnt), 0);

    // Reset pattern arrives LSB first; nothing before the 16th beat.
    h0 = 0;
    for (int k = 0; k < SEQ_LEN - 1; k++) cyc(1'b1, pa[k]);
    cyc(1'b0, 1'b0);
    chk("t1_no_early_hit", h0, 0);
    cyc(1'b1, pa[SEQ_LEN-1]);
    cyc(1'b0, 1'b0);
    chk("t1_hit", h0, 1);
    chk("t1_cnt0", int'(hit_cnt[CNT_W-1:0]), 1);

    // All-zero pattern on lane 1 must still wait for a full window.
    do_clr();
    do_cfg(1'b1, 16'h0000, 16'hFFFF);
    h1 = 0;
    for (int k = 0; k < SEQ_LEN - 1; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t1_zero_early", h1, 0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t1_zero_hit", h1, 1);

    // Alternating stream: overlap hits on beats 16,18,20; non-overlap only on 16.
    do_clr();
    do_cfg(1'b1, 16'hAAAA, 16'hFFFF);
    mode_nonovl = 1'b0;
    h1 = 0;
    for (int k = 0; k < 20; k++) cyc(1'b1, k[0]);
    cyc(1'b0, 1'b0);
    chk("t2_ovl_hits", h1, 3);
    chk("t2_ovl_cnt1", int'(hit_cnt[2*CNT_W-1:CNT_W]), 3);
    do_clr();
    mode_nonovl = 1'b1;
    h1 = 0;
    for (int k = 0; k < 20; k++) cyc(1'b1, k[0]);
    cyc(1'b0, 1'b0);
    chk("t2_nonovl_hits", h1, 1);

    // Masked compare: only the oldest byte matters.
    mode_nonovl = 1'b0;
    do_clr();
    do_cfg(1'b1, 16'h00C3, 16'h00FF);
    h1 = 0;
    for (int k = 0; k < 8; k++) cyc(1'b1, c3[k]);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'($urandom));
    cyc(1'b0, 1'b0);
    chk("t3_masked_hit", h1, 1);
    do_clr();
    do_cfg(1'b1, 16'h00C3, 16'h0000);
    h1 = 0;
    for (int k = 0; k < 8; k++) cyc(1'b1, c3[k]);
    for (int k = 0; k < 30; k++) cyc(1'b1, 1'($urandom));
    cyc(1'b0, 1'b0);
    chk("t3_mask0_nohit", h1, 0);

    // Five back-to-back patterns in non-overlap mode saturate the 2-bit counter.
    mode_nonovl = 1'b1;
    do_clr();
    h0 = 0;
    repeat (5) send16(pa);
    cyc(1'b0, 1'b0);
    chk("t4_hits", h0, 5);
    chk("t4_sat_cnt", int'(hit_cnt[CNT_W-1:0]), 3);
    do_clr();
    chk("t4_clr_cnt", int'(hit_cnt[CNT_W-1:0]), 0);
    h0 = 0;
    for (int k = 0; k < SEQ_LEN - 1; k++) cyc(1'b1, pa[k]);
    cyc(1'b0, 1'b0);
    chk("t4_post_clr_nohit", h0, 0);

    // Reconfigure lane 0 on the completing beat: old pattern still hits.
    mode_nonovl = 1'b0;
    do_clr();
    h0 = 0;
    for (int k = 0; k < SEQ_LEN - 1; k++) cyc(1'b1, pa[k]);
    cyc(1'b1, pa[SEQ_LEN-1]);
    cfg_we   = 1'b1;
    cfg_idx  = 1'b0;
    cfg_pat  = pn;
    cfg_mask = 16'hFFFF;
    cyc(1'b0, 1'b0);
    chk("t5_old_pat_hit", h0, 1);
    h0 = 0;
    send16(pn);
    cyc(1'b0, 1'b0);
    chk("t5_new_pat_hit", h0, 1);
    send16(pa);
    do_cfg(1'b0, pa, 16'hFFFF);

    // Reset mid-pattern and on the hit cycle.
    for (int k = 0; k < 10; k++) cyc(1'b1, pa[k]);
    @(posedge clk);
    #1;
    pulse_rst();
    h0 = 0;
    for (int k = 10; k < SEQ_LEN; k++) cyc(1'b1, pa[k]);
    cyc(1'b0, 1'b0);
    chk("t6_tail_nohit", h0, 0);
    send16(pa);
    @(posedge clk);
    #1;
    chk("t6_hit_before_rst", int'(hit[0]), 1);
    pulse_rst();
    h0 = 0;
    send16(pa);
    cyc(1'b0, 1'b0);
    chk("t6_refill_hit", h0, 1);

    // Randomized stream with sparse clears, mode flips and reconfiguration.
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom % 4) != 0, 1'($urandom));
      if (($urandom % 200) == 0) clr = 1'b1;
      if (($urandom % 150) == 0) mode_nonovl = ~mode_nonovl;
      if (($urandom % 60) == 0) begin
        sh       = $urandom_range(0, 12);
        cfg_we   = 1'b1;
        cfg_idx  = 1'($urandom);
        cfg_pat  = 16'($urandom);
        cfg_mask = (($urandom % 5) == 0) ? 16'h0000 : (16'h000F << sh);
      end
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
